// File: rtl/lap_timer_pkg.sv
// lap_timer_pkg: shared constants and helpers for the lap timer
//   SEG_BLANK  segment pattern for a non-decimal digit
//   dig_mod()  modulus of digit i (tens-of-seconds and tens-of-minutes are mod 6)
//   seg7()     BCD to 7-segment, bit0 = segment a
package lap_timer_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  function automatic logic [3:0] dig_mod(input int i);
    return (i == 2 || i == 4) ? 4'd6 : 4'd10;
  endfunction
  function automatic logic [6:0] seg7(input logic [3:0] b);
    case (b)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/lap_timer_fifo.sv
// lap_fifo: synchronous FIFO holding captured lap counts
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             empties the FIFO (dominates push/pop)
//   push, pop, din    caller only pushes with room and pops when non-empty
//   dout              head entry
//   full, empty, count occupancy status
module lap_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    mem_d = mem_q;
    wp_d = wp_q;
    rp_d = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wp_q] = din;
        wp_d = inc(wp_q);
      end
      if (pop) rp_d = inc(rp_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rp_q];
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/lap_timer.sv
// lap_timer: BCD stopwatch with lap FIFO, lap recall and optional countdown
//   clk, rst_n             clock, asynchronous active-low reset
//   b_run, b_lap, b_rd     debounced level buttons, acted on at rising edge
//   mode_dn, pre_ld, pre_val countdown controls (only with LAP_TIMER_DOWN_EN)
//   seg                    registered 7-seg codes, digit i at [7i+6:7i]
//   s_run, s_hld           running / showing recalled lap
//   lap_cnt, lap_ovf       laps stored / sticky lap-dropped flag
//   alarm                  one-cycle countdown-expired pulse
// Define LAP_TIMER_DOWN_EN to enable preset load and countdown.
module lap_timer import lap_timer_pkg::*; #(
  parameter int SPN  = 1024,
  parameter int SPL  = $clog2(SPN),
  parameter int NDIG = 5,
  parameter int LAPD = 4,
  parameter int LCW  = $clog2(LAPD + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              b_run,
  input  logic              b_lap,
  input  logic              b_rd,
  input  logic              mode_dn,
  input  logic              pre_ld,
  input  logic [NDIG*4-1:0] pre_val,
  output logic [NDIG*7-1:0] seg,
  output logic              s_run,
  output logic              s_hld,
  output logic [LCW-1:0]    lap_cnt,
  output logic              lap_ovf,
  output logic              alarm
);
  localparam int W = NDIG * 4;
  logic [SPL-1:0] presc_q, presc_d;
  logic tick_q, tick_d;
  logic [2:0] btn_q, btn_d;
  logic run_q, run_d, hld_q, hld_d, ovf_q, ovf_d, alm_q, alm_d;
  logic [W-1:0] cnt_q, cnt_d, hold_q, hold_d, cnt_up, cnt_dn, pre_sat, disp, fifo_dout;
  logic [NDIG*7-1:0] seg_q, seg_d;
  logic [NDIG:0] cy, bw;
  logic run_e, lap_e, rd_e, clr, push, pop, full, empty, dn, ld, expire, unused_ok;
  logic [LCW-1:0] fifo_cnt;
  assign presc_d = presc_q == SPL'(SPN - 1) ? '0 : presc_q + SPL'(1);
  assign tick_d = presc_q == SPL'(SPN - 1);
  assign btn_d = {b_rd, b_lap, b_run};
  assign {rd_e, lap_e, run_e} = btn_d & ~btn_q;
`ifdef LAP_TIMER_DOWN_EN
  assign dn = mode_dn;
  assign ld = pre_ld & ~run_q;
  assign unused_ok = cy[NDIG];
`else
  assign dn = 1'b0;
  assign ld = 1'b0;
  assign unused_ok = ^{cy[NDIG], mode_dn, pre_ld};
`endif
  // cy[i]: all digits below i at their wrap value; bw[i]: all digits below i at zero
  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;
  assign disp = hld_q ? hold_q : cnt_q;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam logic [3:0] TOP = dig_mod(i) - 4'd1;
    logic [3:0] d, p;
    assign d = cnt_q[4*i+:4];
    assign p = pre_val[4*i+:4];
    assign cy[i+1] = cy[i] & (d == TOP);
    assign bw[i+1] = bw[i] & (d == 4'd0);
    assign cnt_up[4*i+:4] = cy[i] ? (d == TOP ? 4'd0 : d + 4'd1) : d;
    assign cnt_dn[4*i+:4] = bw[i] ? (d == 4'd0 ? TOP : d - 4'd1) : d;
    assign pre_sat[4*i+:4] = p > TOP ? TOP : p;
    assign seg_d[7*i+:7] = seg7(disp[4*i+:4]);
  end
  assign expire = tick_q & run_q & dn & bw[NDIG];
  assign clr = lap_e & ~run_q;
  assign pop = rd_e & ~empty;
  // a full FIFO still accepts a lap when a recall frees the head in the same cycle
  assign push = lap_e & run_q & (~full | pop);
  always_comb begin
    cnt_d = clr ? '0 : ld ? pre_sat : (tick_q & run_q & ~expire) ? (dn ? cnt_dn : cnt_up) : cnt_q;
    run_d = ~expire & (run_q ^ run_e);
    hld_d = clr ? 1'b0 : rd_e ? ~empty : hld_q;
    hold_d = pop ? fifo_dout : hold_q;
    ovf_d = ~clr & (ovf_q | (lap_e & run_q & ~push));
    alm_d = expire;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q <= 1'b0;
      btn_q <= '0;
      run_q <= 1'b0;
      hld_q <= 1'b0;
      ovf_q <= 1'b0;
      alm_q <= 1'b0;
      cnt_q <= '0;
      hold_q <= '0;
      seg_q <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q <= tick_d;
      btn_q <= btn_d;
      run_q <= run_d;
      hld_q <= hld_d;
      ovf_q <= ovf_d;
      alm_q <= alm_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      seg_q <= seg_d;
    end
  end
  lap_fifo #(.WIDTH(W), .DEPTH(LAPD), .CW(LCW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(clr),
    .push(push),
    .pop(pop),
    .din(cnt_q),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(fifo_cnt)
  );
  assign seg = seg_q;
  assign s_run = run_q;
  assign s_hld = hld_q;
  assign lap_cnt = fifo_cnt;
  assign lap_ovf = ovf_q;
  assign alarm = alm_q;
endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: checks lap_timer against a value-level model (count held as tenths)
module tb_lap_timer;
  localparam int SPN = 4, NDIG = 5, LAPD = 2, LCW = 2, W = 20, SW = 35;
  localparam logic [6:0] TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [SW-1:0] ZERO = {5{7'h3F}};
  localparam logic [SW-1:0] MAXV = {7'h6D, 7'h6F, 7'h6D, 7'h6F, 7'h6F};
  logic clk = 0, rst_n = 0, w_rst_n = 0;
  logic b_run = 0, b_lap = 0, b_rd = 0, mode_dn = 0, pre_ld = 0, w_run = 0;
  logic [W-1:0] pre_val = '0;
  logic [SW-1:0] seg, w_seg;
  logic s_run, s_hld, lap_ovf, alarm, w_srun, w_hld, w_ovf, w_alarm;
  logic [LCW-1:0] lap_cnt, w_cnt;
  int checks = 0, fails = 0;
  int m_v = 0, m_hold = 0, ncyc = 0;
  int q[$];
  logic m_run = 0, m_hld = 0, m_ovf = 0, m_alarm = 0, pr = 0, pl = 0, pd = 0;
  logic [SW-1:0] m_seg = '0;

  always #5 clk = ~clk;

  lap_timer #(.SPN(SPN), .NDIG(NDIG), .LAPD(LAPD)) dut (
    .clk(clk), .rst_n(rst_n), .b_run(b_run), .b_lap(b_lap), .b_rd(b_rd),
    .mode_dn(mode_dn), .pre_ld(pre_ld), .pre_val(pre_val), .seg(seg), .s_run(s_run),
    .s_hld(s_hld), .lap_cnt(lap_cnt), .lap_ovf(lap_ovf), .alarm(alarm)
  );
  lap_timer #(.SPN(2), .NDIG(NDIG), .LAPD(LAPD)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .b_run(w_run), .b_lap(1'b0), .b_rd(1'b0),
    .mode_dn(1'b0), .pre_ld(1'b0), .pre_val(20'h0), .seg(w_seg), .s_run(w_srun),
    .s_hld(w_hld), .lap_cnt(w_cnt), .lap_ovf(w_ovf), .alarm(w_alarm)
  );

  function automatic logic [SW-1:0] segs(input int v);
    return {TBL[(v/6000)%6], TBL[(v/600)%10], TBL[(v/100)%6], TBL[(v/10)%10], TBL[v%10]};
  endfunction
  function automatic int bcd2v(input logic [W-1:0] p);
    int r = 0;
    for (int i = 0; i < 5; i++) begin
      int d, lim, wt;
      d = int'(p[4*i+:4]);
      lim = (i == 2 || i == 4) ? 5 : 9;
      wt = i == 0 ? 1 : i == 1 ? 10 : i == 2 ? 100 : i == 3 ? 600 : 6000;
      r += (d > lim ? lim : d) * wt;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: count kept as a plain number of tenths, FIFO as a queue
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_v = 0; m_hold = 0; ncyc = 0; q.delete();
      m_run = 0; m_hld = 0; m_ovf = 0; m_alarm = 0; pr = 0; pl = 0; pd = 0; m_seg = '0;
    end else begin
      logic tick, re, le, de, clr, expire, ld, dn;
      tick = ncyc > 0 && ncyc % SPN == 0;
      ncyc++;
      re = b_run & ~pr; le = b_lap & ~pl; de = b_rd & ~pd;
      pr = b_run; pl = b_lap; pd = b_rd;
      m_seg = segs(m_hld ? m_hold : m_v);
`ifdef LAP_TIMER_DOWN_EN
      dn = mode_dn;
      ld = pre_ld & ~m_run;
`else
      dn = 0;
      ld = 0;
`endif
      expire = m_run && tick && dn && m_v == 0;
      m_alarm = expire;
      clr = le && !m_run;
      if (clr) begin
        m_v = 0; q.delete(); m_ovf = 0; m_hld = 0;
      end else begin
        if (de) begin
          if (q.size() > 0) begin m_hold = q.pop_front(); m_hld = 1; end
          else m_hld = 0;
        end
        if (le && m_run) begin
          if (q.size() < LAPD) q.push_back(m_v);
          else m_ovf = 1;
        end
        if (ld) m_v = bcd2v(pre_val);
        else if (m_run && tick && !expire) m_v = dn ? m_v - 1 : (m_v + 1) % 36000;
      end
      m_run = expire ? 1'b0 : m_run ^ re;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("seg", seg, m_seg);
    chk("s_run", s_run, m_run);
    chk("s_hld", s_hld, m_hld);
    chk("lap_cnt", lap_cnt, q.size());
    chk("lap_ovf", lap_ovf, m_ovf);
    chk("alarm", alarm, m_alarm);
  end

  task automatic press(input logic [2:0] m);
    @(negedge clk);
    {b_rd, b_lap, b_run} = m;
    @(negedge clk);
    {b_rd, b_lap, b_run} = 3'b000;
  endtask
  task automatic wait_v(input int t);
    int n = 0;
    while (m_v != t && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (m_v != t) begin fails++; $display("FAIL wait_v: count %0d never reached %0d", m_v, t); end
  endtask

  initial begin
    fork
      begin
        int exp_lap, hits;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 0);
        chk("rst_run", s_run, 0);
        #2 rst_n = 1;
        press(3'b001);
        wait_v(12);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_seg", seg, 0);
        chk("mid_rst_run", s_run, 0);
        chk("mid_rst_cnt", lap_cnt, 0);
        @(negedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;
        chk("first_seg", seg, ZERO);
        press(3'b001);
        wait_v(10);
        @(posedge clk); #1;
        chk("ten_d1", seg[13:7], 7'h06);
        chk("ten_d0", seg[6:0], 7'h3F);
        wait_v(600);
        @(posedge clk); #1;
        chk("min_d3", seg[27:21], 7'h06);
        chk("min_rest", {seg[34:28], seg[20:0]}, {4{7'h3F}});
        press(3'b001);
        press(3'b010);
        @(posedge clk); #1;
        chk("clr_seg", seg, ZERO);
        press(3'b001);
        wait_v(3); press(3'b010);
        wait_v(7); press(3'b010);
        wait_v(8); press(3'b010);
        chk("laps_cnt", lap_cnt, 2);
        chk("laps_ovf", lap_ovf, 1);
        press(3'b100);
        @(posedge clk); #1;
        chk("rd1_seg", seg[6:0], 7'h4F);
        chk("rd1_hld", s_hld, 1);
        press(3'b100);
        @(posedge clk); #1;
        chk("rd2_seg", seg[6:0], 7'h07);
        press(3'b100);
        chk("rd3_hld", s_hld, 0);
        chk("rd3_cnt", lap_cnt, 0);
        press(3'b001);
        press(3'b010);
        chk("sclr_ovf", lap_ovf, 0);
        chk("sclr_run", s_run, 0);
        press(3'b001);
        wait_v(5);
        press(3'b001);
        press(3'b011);
        @(posedge clk); #1;
        chk("runclr_seg", seg, ZERO);
        chk("runclr_run", s_run, 1);
        while (ncyc % SPN != 0) @(negedge clk);
        exp_lap = m_v;
        b_lap = 1;
        @(negedge clk);
        b_lap = 0;
        press(3'b100);
        @(posedge clk); #1;
        chk("tick_lap", seg, segs(exp_lap));
        press(3'b001);
        press(3'b010);
`ifdef LAP_TIMER_DOWN_EN
        mode_dn = 1;
        pre_val = 20'h99999;
        @(negedge clk); pre_ld = 1;
        @(negedge clk); pre_ld = 0;
        @(posedge clk); #1;
        chk("sat_seg", seg, MAXV);
        pre_val = 20'h00025;
        @(negedge clk); pre_ld = 1;
        @(negedge clk); pre_ld = 0;
        press(3'b001);
        hits = 0;
        for (int n = 0; n < 200; n++) begin
          @(negedge clk);
          if (alarm) hits++;
        end
        chk("alarm_hits", hits, 1);
        chk("dn_run", s_run, 0);
        chk("dn_seg", seg, ZERO);
        mode_dn = 0;
`else
        hits = 0;
        for (int n = 0; n < 20; n++) begin
          @(negedge clk);
          if (alarm) hits++;
        end
        chk("alarm_off", hits, 0);
`endif
      end
      begin
        int n;
        repeat (2) @(negedge clk);
        w_rst_n = 1;
        @(negedge clk); w_run = 1;
        @(negedge clk); w_run = 0;
        n = 0;
        while (w_seg != MAXV && n < 80000) begin @(negedge clk); n++; end
        chk("wrap_reach", w_seg, MAXV);
        n = 0;
        while (w_seg == MAXV && n < 10) begin @(negedge clk); n++; end
        chk("wrap_zero", w_seg, ZERO);
        chk("wrap_run", w_srun, 1);
        chk("wrap_idle", {w_hld, w_cnt, w_ovf, w_alarm}, 0);
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
